// File: rtl/pipe_credit_rx_pkg.sv
// Shared sizing helpers for the credit pipe receiver and its sender.
// Both ends size pointers and occupancy counters with these functions.
package pipe_credit_rx_pkg;

    // Pointer width for a DEPTH-entry buffer (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width able to hold 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_credit_rx_mem.sv
// DEPTH x WIDTH register array, one write port, asynchronous read port.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side. No reset.
module pipe_credit_rx_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_credit_rx.sv
// Receiver of a never-stalling valid-only pipe: buffers into a circular
// buffer, presents ready/valid output, returns one credit per dequeue.
// Ports: clk, reset (async active-low), io_enq_* in, io_deq_* out,
// io_credit pulse, io_count occupancy, io_overflow sticky error.
module pipe_credit_rx
    import pipe_credit_rx_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNTW  = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_enq_valid,
    input  logic [WIDTH-1:0] io_enq_bits,
    input  logic             io_deq_ready,
    output logic             io_deq_valid,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic             io_credit,
    output logic [CNTW-1:0]  io_count,
    output logic             io_overflow
);

    localparam int              PW    = ptr_w(DEPTH);
    localparam logic [PW-1:0]   LAST  = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] FULLC = CNTW'(DEPTH);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            credit;
    logic            overflow;

    logic full;
    logic deq_fire;
    logic enq_fire;
    logic ovf_evt;

    assign full     = (count == FULLC);
    assign deq_fire = io_deq_valid & io_deq_ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign enq_fire = io_enq_valid & (~full | deq_fire);
    assign ovf_evt  = io_enq_valid & full & ~deq_fire;

    pipe_credit_rx_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (enq_fire),
        .waddr (wr_ptr),
        .wdata (io_enq_bits),
        .raddr (rd_ptr),
        .rdata (io_deq_bits)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            credit   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            unique case (1'b1)
                enq_fire & ~deq_fire: count <= count + 1'b1;
                deq_fire & ~enq_fire: count <= count - 1'b1;
                default:              count <= count;
            endcase
            credit <= deq_fire;
            if (ovf_evt) begin
                overflow <= 1'b1;
            end
        end
    end

    assign io_deq_valid = (count != '0);
    assign io_count     = count;
    assign io_credit    = credit;
    assign io_overflow  = overflow;

endmodule

// File: tb/tb_pipe_credit_rx.sv
// Directed bench for pipe_credit_rx: DEPTH=4 main instance plus a
// DEPTH=3 instance for non-power-of-two wrap-around streaming.
module tb_pipe_credit_rx;

    logic       clk;
    logic       reset;

    logic       ev;
    logic [7:0] eb;
    logic       dr;
    logic       dv;
    logic [7:0] db;
    logic       cr;
    logic [2:0] cnt;
    logic       ovf;

    logic       ev3;
    logic [7:0] eb3;
    logic       dr3;
    logic       dv3;
    logic [7:0] db3;
    logic       cr3;
    logic [1:0] cnt3;
    logic       ovf3;

    int total;
    int bad;

    pipe_credit_rx #(.WIDTH(8), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_enq_valid (ev),
        .io_enq_bits  (eb),
        .io_deq_ready (dr),
        .io_deq_valid (dv),
        .io_deq_bits  (db),
        .io_credit    (cr),
        .io_count     (cnt),
        .io_overflow  (ovf)
    );

    pipe_credit_rx #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk          (clk),
        .reset        (reset),
        .io_enq_valid (ev3),
        .io_enq_bits  (eb3),
        .io_deq_ready (dr3),
        .io_deq_valid (dv3),
        .io_deq_bits  (db3),
        .io_credit    (cr3),
        .io_count     (cnt3),
        .io_overflow  (ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ev = 1'b0; eb = '0; dr = 1'b0;
        ev3 = 1'b0; eb3 = '0; dr3 = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) begin
            ev = 1'b1;
            eb = 8'(i);
            tick();
        end
        ev = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (dv !== 1'b0 || cnt !== 3'd0 || cr !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset: dv=%b cnt=%0d cr=%b ovf=%b want 0 0 0 0",
                     dv, cnt, cr, ovf);
        end
    endtask

    task automatic test_single();
        do_reset();
        ev = 1'b1; eb = 8'hA5;
        tick();
        ev = 1'b0;
        total++;
        if (dv !== 1'b1 || db !== 8'hA5 || cnt !== 3'd1) begin
            bad++;
            $display("FAIL single_enq: dv=%b db=%h cnt=%0d want 1 a5 1",
                     dv, db, cnt);
        end
        dr = 1'b1;
        tick();
        dr = 1'b0;
        total++;
        if (cr !== 1'b1 || cnt !== 3'd0 || dv !== 1'b0) begin
            bad++;
            $display("FAIL single_deq: cr=%b cnt=%0d dv=%b want 1 0 0",
                     cr, cnt, dv);
        end
        tick();
        total++;
        if (cr !== 1'b0) begin
            bad++;
            $display("FAIL single_credit_len: cr=%b want 0", cr);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        fill4();
        total++;
        if (cnt !== 3'd4 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL fill: cnt=%0d ovf=%b want 4 0", cnt, ovf);
        end
        dr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (dv !== 1'b1 || db !== 8'(i)) begin
                bad++;
                $display("FAIL drain_data[%0d]: dv=%b db=%h want 1 %h",
                         i, dv, db, 8'(i));
            end
            tick();
            total++;
            if (cr !== 1'b1) begin
                bad++;
                $display("FAIL drain_credit[%0d]: cr=%b want 1", i, cr);
            end
        end
        dr = 1'b0;
        tick();
        total++;
        if (cr !== 1'b0 || cnt !== 3'd0 || dv !== 1'b0) begin
            bad++;
            $display("FAIL drain_end: cr=%b cnt=%0d dv=%b want 0 0 0",
                     cr, cnt, dv);
        end
        // Ready while empty must not return a credit.
        dr = 1'b1;
        tick();
        tick();
        dr = 1'b0;
        total++;
        if (cr !== 1'b0 || cnt !== 3'd0) begin
            bad++;
            $display("FAIL empty_ready: cr=%b cnt=%0d want 0 0", cr, cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fill4();
        ev = 1'b1; eb = 8'h55;
        tick();
        ev = 1'b0;
        total++;
        if (ovf !== 1'b1 || cnt !== 3'd4) begin
            bad++;
            $display("FAIL overflow: ovf=%b cnt=%0d want 1 4", ovf, cnt);
        end
        dr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (dv !== 1'b1 || db !== 8'(i)) begin
                bad++;
                $display("FAIL ovf_drain[%0d]: dv=%b db=%h want 1 %h",
                         i, dv, db, 8'(i));
            end
            tick();
        end
        dr = 1'b0;
        total++;
        if (dv !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after: dv=%b ovf=%b want 0 1", dv, ovf);
        end
    endtask

    task automatic test_full_simul();
        logic [7:0] exp [4];
        exp[0] = 8'h02; exp[1] = 8'h03; exp[2] = 8'h04; exp[3] = 8'h66;
        do_reset();
        fill4();
        ev = 1'b1; eb = 8'h66; dr = 1'b1;
        tick();
        ev = 1'b0; dr = 1'b0;
        total++;
        if (ovf !== 1'b0 || cnt !== 3'd4 || cr !== 1'b1) begin
            bad++;
            $display("FAIL full_simul: ovf=%b cnt=%0d cr=%b want 0 4 1",
                     ovf, cnt, cr);
        end
        dr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dv !== 1'b1 || db !== exp[i]) begin
                bad++;
                $display("FAIL simul_drain[%0d]: dv=%b db=%h want 1 %h",
                         i, dv, db, exp[i]);
            end
            tick();
        end
        dr = 1'b0;
        total++;
        if (dv !== 1'b0 || cnt !== 3'd0) begin
            bad++;
            $display("FAIL simul_end: dv=%b cnt=%0d want 0 0", dv, cnt);
        end
    endtask

    task automatic test_wrap_d3();
        int credits;
        int maxcnt;
        credits = 0;
        maxcnt  = 0;
        do_reset();
        dr3 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ev3 = 1'b1;
            eb3 = 8'(8'h30 + k);
            tick();
            if (cr3 === 1'b1) credits++;
            if (int'(cnt3) > maxcnt) maxcnt = int'(cnt3);
            total++;
            if (dv3 !== 1'b1 || db3 !== 8'(8'h30 + k)) begin
                bad++;
                $display("FAIL wrap_data[%0d]: dv=%b db=%h want 1 %h",
                         k, dv3, db3, 8'(8'h30 + k));
            end
        end
        ev3 = 1'b0;
        tick();
        if (cr3 === 1'b1) credits++;
        tick();
        if (cr3 === 1'b1) credits++;
        dr3 = 1'b0;
        total++;
        if (credits != 10 || maxcnt > 1 || cnt3 !== 2'd0) begin
            bad++;
            $display("FAIL wrap_totals: credits=%0d max=%0d cnt=%0d want 10 <=1 0",
                     credits, maxcnt, cnt3);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        fill4();
        ev = 1'b1; eb = 8'h99;
        tick();
        ev = 1'b0;
        dr = 1'b1;
        tick();
        dr = 1'b0;
        total++;
        if (cnt !== 3'd3 || cr !== 1'b1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: cnt=%0d cr=%b ovf=%b want 3 1 1",
                     cnt, cr, ovf);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (dv !== 1'b0 || cnt !== 3'd0 || cr !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: dv=%b cnt=%0d cr=%b ovf=%b want 0 0 0 0",
                     dv, cnt, cr, ovf);
        end
        tick();
        reset = 1'b1;
        ev = 1'b1; eb = 8'h77;
        tick();
        ev = 1'b0;
        total++;
        if (dv !== 1'b1 || db !== 8'h77 || cnt !== 3'd1) begin
            bad++;
            $display("FAIL post_reset: dv=%b db=%h cnt=%0d want 1 77 1",
                     dv, db, cnt);
        end
        dr = 1'b1;
        tick();
        tick();
        dr = 1'b0;
        total++;
        if (dv !== 1'b0 || cnt !== 3'd0) begin
            bad++;
            $display("FAIL stale: dv=%b cnt=%0d want 0 0", dv, cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_full_simul();
        test_wrap_d3();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_credit_rx.md
Name: pipe_credit_rx

Overview:
Receiving end of the valid-only, no-backpressure pipe: the sender side launches valid/bits through fixed-latency register stages and never stalls.
This block absorbs that stream into a DEPTH-entry circular buffer and presents it as a decoupled ready/valid output.
It returns one credit pulse per consumed entry so the sender can limit itself to DEPTH outstanding transfers.
Overflow can only occur on a sender credit violation; it is flagged sticky, never silently tolerated.

Parameters:
WIDTH, 8, data bits per transfer
DEPTH, 4, buffer entries (integer >= 2; need not be a power of two)
CNTW, clog2(DEPTH+1), width of occupancy count (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
io_enq_valid  input  1  transfer present this cycle; cannot be refused
io_enq_bits  input  WIDTH  transfer data
io_deq_ready  input  1  consumer accepts head entry
io_deq_valid  output  1  head entry available
io_deq_bits  output  WIDTH  head entry data
io_credit  output  1  one-cycle pulse, one credit returned to sender
io_count  output  CNTW  current occupancy, 0..DEPTH
io_overflow  output  1  sticky: a transfer arrived while full with no dequeue

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - wr_ptr, rd_ptr, count, io_credit and io_overflow all go to 0 immediately.
  - io_deq_valid=0, io_count=0.
  - Storage is not reset; io_deq_bits is don't-care while io_deq_valid=0.
- Reset mid-operation: all buffered entries are discarded. No credits are emitted for discarded entries; the sender resets alongside and restores its own credits.
- enq_fire = io_enq_valid & (count<DEPTH | deq_fire).
- deq_fire = io_deq_valid & io_deq_ready.
- io_deq_valid = (count!=0). io_deq_bits = mem[rd_ptr], driven from registers with no combinational path from io_enq_*.
- Latency: a transfer written at edge N is visible on io_deq_* in the cycle after edge N. There is no same-cycle bypass, even when empty.
- On enq_fire: mem[wr_ptr] <= io_enq_bits; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
- On deq_fire: rd_ptr advances with the same explicit wrap.
- count <= count + enq_fire - deq_fire.
  - Simultaneous enq and deq: count unchanged, both pointers advance.
  - Simultaneous enq and deq when full: legal, accepted, count stays DEPTH.
- Overflow: io_enq_valid & count==DEPTH & !deq_fire.
  - The data is dropped; pointers and count are unchanged.
  - io_overflow <= 1 and holds until reset.
- Empty: io_deq_ready while empty has no effect; no credit is returned.
- Credit: io_credit <= deq_fire (registered, exactly one cycle after each handshake, one pulse per entry).
  - Back-to-back dequeues give back-to-back pulses.
  - The sum of pulses equals the number of dequeued entries.
- io_count = count (registered).

Decomposition:
- Shared package: ptr_w(DEPTH) = clog2(DEPTH) and the count-width function clog2(DEPTH+1). These are reused by the sender-side credit counter, which must agree on CNTW.
- One sub-module, pipe_credit_rx_mem: DEPTH x WIDTH register array with write enable/address and asynchronous read address. No reset.
- Pointer, count, credit and overflow logic stay in the top.

Test Plan:
1. Reset, then a single enq 0xA5 with io_deq_ready=0.
   -> Next cycle: io_deq_valid=1, io_deq_bits=0xA5, io_count=1.
   -> Set ready for one cycle: io_credit=1 exactly one cycle later, io_count=0.
2. DEPTH=4, enq 0x01..0x04 on consecutive cycles with ready=0.
   -> io_count=4, io_overflow=0.
   -> Then ready=1 for 4 cycles: outputs 0x01,0x02,0x03,0x04 in order, then 4 consecutive io_credit pulses.
3. Fill to 4, then a 5th enq 0x55 with ready=0.
   -> io_overflow=1 sticky, io_count stays 4.
   -> Drain yields 0x01..0x04 only; 0x55 never appears.
4. Full, then enq 0x66 in the same cycle as a dequeue of 0x01.
   -> Accepted, io_overflow stays 0, io_count=4.
   -> Drain order: 0x02,0x03,0x04,0x66.
5. Wrap-around with DEPTH=3: stream 10 values with ready=1 continuously.
   -> Each value appears one cycle after enq, in order, with no loss.
   -> 10 credit pulses total; io_count never exceeds 1.
6. Hold 3 entries, then pull reset low mid-cycle (asynchronous).
   -> io_deq_valid, io_count, io_credit and io_overflow are 0 immediately.
   -> After release, enq 0x77 is the only entry output, and no stale data appears.
